ifu_pc_gen: RTL and testbench
=============================

Name: ifu_pc_gen

Overview:
- Fetch-stage PC generator and instruction-bus master, directly upstream of decode/execute.
- Consumes the redirect that the execute-stage branch unit produces: the taken flag plus the target. The taken flag is already qualified by branch valid, and it covers conditional branches, jirl and bl.
- Also accepts a higher-priority exception redirect.
- Issues one instruction-bus request at a time, discards responses made stale by a redirect, and hands each {pc, inst} to decode over a valid/ready handshake.

Parameters:
- RESET_PC, 32'h1c000000, first fetch address after reset.

Ports:
- clk  in  1  clock
- resetn  in  1  asynchronous active-low reset
- br_redirect  in  1  execute-stage branch taken (already valid-qualified)
- br_target  in  32  branch/jirl target
- exc_redirect  in  1  exception/ertn redirect, priority over br_redirect
- exc_target  in  32  exception entry/return PC
- inst_req  out  1  instruction-bus request
- inst_addr  out  32  request address, word aligned
- inst_addr_ok  in  1  request accepted this cycle
- inst_data_ok  in  1  read data returned this cycle
- inst_rdata  in  32  read data
- fd_valid  out  1  {fd_pc, fd_inst} valid to decode
- fd_pc  out  32  PC of delivered instruction
- fd_inst  out  32  delivered instruction
- de_ready  in  1  decode accepts this cycle

Behaviour:

Clock and reset:
- One clock. Reset is asynchronous, active-low, on resetn.
- While resetn=0: pc=RESET_PC, state=RST, cancel=0, out_valid=0, inst_req=0, fd_valid=0, fd_pc=0, fd_inst=0.
- State is RST for the first clk edge after resetn rises, then REQ. inst_req first asserts in the cycle after that edge.

Redirect:
- redirect = exc_redirect | br_redirect.
- new_pc = exc_redirect ? exc_target : br_target, with [1:0] forced to 2'b00. Misaligned-target exceptions are handled elsewhere.

States:
- RST: inst_req=0 → REQ.
- REQ: inst_req=1, inst_addr=pc.
  - addr_ok=0: stay. If redirect, pc<=new_pc; changing the address of an unaccepted request is legal.
  - addr_ok=1 → WAIT. If redirect in the same cycle, the old pc was accepted: pc<=new_pc, cancel<=1.
- WAIT: inst_req=0.
  - redirect with no data_ok: pc<=new_pc, cancel<=1, stay.
  - data_ok with (cancel | redirect): drop data, cancel<=0, pc<=(redirect ? new_pc : pc) → REQ.
  - data_ok otherwise: buf_inst<=inst_rdata, buf_pc<=pc, out_valid<=1 → OUT.
- OUT: inst_req=0.
  - redirect: out_valid<=0, pc<=new_pc → REQ.
  - de_ready=1: out_valid<=0, pc<=pc+4 → REQ.
  - else stay; buffer held stable.

Outputs:
- fd_valid = out_valid & ~redirect (combinational kill).
- fd_pc = buf_pc, fd_inst = buf_inst.
- Decode must not consume while redirect=1; fd_valid guarantees this.

Rules:
- At most one outstanding bus transaction; cancel is a single bit.
- inst_data_ok outside WAIT is a protocol error and is ignored.
- pc+4 wraps modulo 2^32 (32'hfffffffc → 0).
- Minimum throughput: 1 instruction per 3 cycles (REQ/WAIT/OUT) with single-cycle addr_ok and data_ok.
- Reset mid-transaction: the bus slave is reset by the same resetn, so no late data_ok is expected. The FSM returns to RST regardless.

Decomposition:
- Shared defines header holds the FSM encodings (IFU_RST/REQ/WAIT/OUT, 2-bit) and the RESET_PC default constant.
- Optional sub-module ifu_out_buf: one-entry {pc, inst} holding register with valid, load and clear. Everything else stays in ifu_pc_gen.

Test Plan:
1. Reset release, addr_ok and data_ok each 1 cycle after req, rdata=32'h02800400, de_ready=1 → inst_addr=0x1c000000; fd_valid with fd_pc=0x1c000000, fd_inst=0x02800400; next inst_addr=0x1c000004.
2. Decode stall: de_ready=0 for 5 cycles in OUT → fd_valid stays 1 with fd_pc/fd_inst stable; no inst_req until de_ready=1; then inst_addr=pc+4.
3. Branch redirect in WAIT: br_redirect=1, br_target=0x1c000100 one cycle before data_ok → returned data dropped (no fd_valid); next inst_addr=0x1c000100.
4. Simultaneous addr_ok and br_redirect (target 0x1c000200) in REQ → old response discarded; next request to 0x1c000200. Simultaneous exc_redirect (0x1c008000) and br_redirect → 0x1c008000 wins.
5. Redirect in OUT with de_ready=1 → fd_valid=0 that cycle; next inst_addr=target. Misaligned br_target=0x1c000103 → inst_addr=0x1c000100.
6. Async reset asserted mid-WAIT → outputs return to reset values immediately, without waiting for a clk edge; after release, fetch restarts at 0x1c000000.

Source files
------------

// File: rtl/ifu_pc_gen_pkg.sv
// ifu_pc_gen_pkg: shared FSM encodings, reset PC and alignment helper for the fetch stage
package ifu_pc_gen_pkg;

    typedef enum logic [1:0] {
        IFU_RST  = 2'd0,
        IFU_REQ  = 2'd1,
        IFU_WAIT = 2'd2,
        IFU_OUT  = 2'd3
    } ifu_state_e;

    localparam logic [31:0] IFU_RESET_PC = 32'h1c000000;

    // Fetch addresses are always word aligned; misaligned targets are trapped elsewhere.
    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/ifu_out_buf.sv
// ifu_out_buf: one-entry {pc, inst} holding register presented to decode
module ifu_out_buf (
    input  logic        clk,
    input  logic        resetn,
    input  logic        load_i,
    input  logic        clear_i,
    input  logic [31:0] pc_i,
    input  logic [31:0] inst_i,
    output logic        valid_o,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o
);

    logic        valid_q;
    logic [31:0] pc_q;
    logic [31:0] inst_q;

    // Load captures a fresh instruction; clear only drops valid so the payload stays stable.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            valid_q <= 1'b0;
            pc_q    <= 32'd0;
            inst_q  <= 32'd0;
        end else if (load_i) begin
            valid_q <= 1'b1;
            pc_q    <= pc_i;
            inst_q  <= inst_i;
        end else if (clear_i) begin
            valid_q <= 1'b0;
        end
    end

    assign valid_o = valid_q;
    assign pc_o    = pc_q;
    assign inst_o  = inst_q;

endmodule

// File: rtl/ifu_pc_gen.sv
// ifu_pc_gen: fetch PC generator and single-outstanding instruction-bus master
module ifu_pc_gen
    import ifu_pc_gen_pkg::*;
#(
    parameter logic [31:0] RESET_PC = IFU_RESET_PC
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        br_redirect,
    input  logic [31:0] br_target,
    input  logic        exc_redirect,
    input  logic [31:0] exc_target,
    output logic        inst_req,
    output logic [31:0] inst_addr,
    input  logic        inst_addr_ok,
    input  logic        inst_data_ok,
    input  logic [31:0] inst_rdata,
    output logic        fd_valid,
    output logic [31:0] fd_pc,
    output logic [31:0] fd_inst,
    input  logic        de_ready
);

    ifu_state_e  state_q;
    logic [31:0] pc_q;
    logic        cancel_q;
    logic        redirect;
    logic [31:0] new_pc;
    logic        buf_load;
    logic        buf_clear;
    logic        buf_valid;

    assign redirect = exc_redirect | br_redirect;
    assign new_pc   = word_align(exc_redirect ? exc_target : br_target);

    // Fetch FSM: cancel marks an accepted request whose response must be discarded.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IFU_RST;
            pc_q     <= RESET_PC;
            cancel_q <= 1'b0;
        end else begin
            case (state_q)
                IFU_RST: state_q <= IFU_REQ;
                IFU_REQ: begin
                    if (redirect) pc_q <= new_pc;
                    if (inst_addr_ok) begin
                        state_q  <= IFU_WAIT;
                        cancel_q <= redirect;
                    end
                end
                IFU_WAIT: begin
                    if (inst_data_ok) begin
                        if (cancel_q || redirect) begin
                            cancel_q <= 1'b0;
                            state_q  <= IFU_REQ;
                            if (redirect) pc_q <= new_pc;
                        end else begin
                            state_q <= IFU_OUT;
                        end
                    end else if (redirect) begin
                        pc_q     <= new_pc;
                        cancel_q <= 1'b1;
                    end
                end
                IFU_OUT: begin
                    if (redirect) begin
                        pc_q    <= new_pc;
                        state_q <= IFU_REQ;
                    end else if (de_ready) begin
                        pc_q    <= pc_q + 32'd4;
                        state_q <= IFU_REQ;
                    end
                end
                default: state_q <= IFU_RST;
            endcase
        end
    end

    assign buf_load  = (state_q == IFU_WAIT) & inst_data_ok & ~cancel_q & ~redirect;
    assign buf_clear = (state_q == IFU_OUT) & (redirect | de_ready);

    ifu_out_buf u_out_buf (
        .clk     (clk),
        .resetn  (resetn),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .pc_i    (pc_q),
        .inst_i  (inst_rdata),
        .valid_o (buf_valid),
        .pc_o    (fd_pc),
        .inst_o  (fd_inst)
    );

    assign inst_req  = (state_q == IFU_REQ);
    assign inst_addr = pc_q;
    assign fd_valid  = buf_valid & ~redirect;

endmodule

// File: tb/tb_ifu_pc_gen.sv
// tb_ifu_pc_gen: directed table-driven bench for the fetch PC generator
module tb_ifu_pc_gen;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        br_redirect = 1'b0;
    logic [31:0] br_target = 32'd0;
    logic        exc_redirect = 1'b0;
    logic [31:0] exc_target = 32'd0;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok = 1'b0;
    logic        inst_data_ok = 1'b0;
    logic [31:0] inst_rdata = 32'd0;
    logic        fd_valid;
    logic [31:0] fd_pc;
    logic [31:0] fd_inst;
    logic        de_ready = 1'b0;

    int total = 0;
    int passed = 0;

    typedef struct {
        logic        br;
        logic [31:0] bt;
        logic        exc;
        logic [31:0] et;
        logic        aok;
        logic        dok;
        logic [31:0] rd;
        logic        rdy;
        logic        req;
        logic [31:0] addr;
        logic        fv;
        logic [31:0] fpc;
        logic [31:0] finst;
    } vec_t;

    vec_t tbl[$];

    ifu_pc_gen dut (
        .clk          (clk),
        .resetn       (resetn),
        .br_redirect  (br_redirect),
        .br_target    (br_target),
        .exc_redirect (exc_redirect),
        .exc_target   (exc_target),
        .inst_req     (inst_req),
        .inst_addr    (inst_addr),
        .inst_addr_ok (inst_addr_ok),
        .inst_data_ok (inst_data_ok),
        .inst_rdata   (inst_rdata),
        .fd_valid     (fd_valid),
        .fd_pc        (fd_pc),
        .fd_inst      (fd_inst),
        .de_ready     (de_ready)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic br, logic [31:0] bt, logic exc, logic [31:0] et,
                                logic aok, logic dok, logic [31:0] rd, logic rdy,
                                logic req, logic [31:0] addr, logic fv,
                                logic [31:0] fpc, logic [31:0] finst);
        vec_t v;
        v.br = br; v.bt = bt; v.exc = exc; v.et = et;
        v.aok = aok; v.dok = dok; v.rd = rd; v.rdy = rdy;
        v.req = req; v.addr = addr; v.fv = fv; v.fpc = fpc; v.finst = finst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Drive one cycle of inputs, check outputs before the edge, then advance past the edge.
    task automatic apply(input vec_t v, input string tag);
        br_redirect  = v.br;  br_target  = v.bt;
        exc_redirect = v.exc; exc_target = v.et;
        inst_addr_ok = v.aok; inst_data_ok = v.dok;
        inst_rdata   = v.rd;  de_ready   = v.rdy;
        #1;
        chk({tag, " inst_req"}, {31'd0, inst_req}, {31'd0, v.req});
        chk({tag, " inst_addr"}, inst_addr, v.addr);
        chk({tag, " fd_valid"}, {31'd0, fd_valid}, {31'd0, v.fv});
        if (v.fv) begin
            chk({tag, " fd_pc"}, fd_pc, v.fpc);
            chk({tag, " fd_inst"}, fd_inst, v.finst);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Basic fetch, decode stall, redirects in WAIT/REQ/OUT, priority and alignment
        tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,32'h1c000000,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,0,1, 1,32'h1c000000,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'h02800400,1, 0,32'h1c000000,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000000,1,32'h1c000000,32'h02800400));
        tbl.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h1c000004,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'haaaa0001,0, 0,32'h1c000004,0,0,0));
        for (int i = 0; i < 5; i++)
            tbl.push_back(mk(0,0,0,0, 0,0,0,0, 0,32'h1c000004,1,32'h1c000004,32'haaaa0001));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000004,1,32'h1c000004,32'haaaa0001));
        tbl.push_back(mk(0,0,0,0, 1,0,0,0, 1,32'h1c000008,0,0,0));
        tbl.push_back(mk(1,32'h1c000100,0,0, 0,0,0,0, 0,32'h1c000008,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'hbad00001,1, 0,32'h1c000100,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,0,1, 1,32'h1c000100,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'h11110000,1, 0,32'h1c000100,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000100,1,32'h1c000100,32'h11110000));
        tbl.push_back(mk(1,32'h1c000200,0,0, 1,0,0,1, 1,32'h1c000104,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'hbad00002,1, 0,32'h1c000200,0,0,0));
        tbl.push_back(mk(1,32'h1c000300,1,32'h1c008000, 0,0,0,1, 1,32'h1c000200,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,0,1, 1,32'h1c008000,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'h22220000,1, 0,32'h1c008000,0,0,0));
        tbl.push_back(mk(1,32'h1c000103,0,0, 0,0,0,1, 0,32'h1c008000,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,0,1, 1,32'h1c000100,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'h33330000,1, 0,32'h1c000100,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000100,1,32'h1c000100,32'h33330000));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 1,32'h1c000104,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'hbad00003,1, 1,32'h1c000104,0,0,0));
        tbl.push_back(mk(0,0,0,0, 1,0,0,1, 1,32'h1c000104,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000104,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,1,32'h44440000,1, 0,32'h1c000104,0,0,0));
        tbl.push_back(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000104,1,32'h1c000104,32'h44440000));

        repeat (2) @(posedge clk);
        #1;
        chk("rst inst_req", {31'd0, inst_req}, 32'd0);
        chk("rst inst_addr", inst_addr, 32'h1c000000);
        chk("rst fd_valid", {31'd0, fd_valid}, 32'd0);
        chk("rst fd_pc", fd_pc, 32'd0);
        chk("rst fd_inst", fd_inst, 32'd0);
        resetn = 1'b1;
        foreach (tbl[i]) apply(tbl[i], $sformatf("vec%0d", i));

        // PC wrap, then exception redirect colliding with data_ok in WAIT
        apply(mk(0,0,1,32'hfffffffd, 0,0,0,0, 1,32'h1c000108,0,0,0), "wrap0");
        apply(mk(0,0,0,0, 1,0,0,0, 1,32'hfffffffc,0,0,0), "wrap1");
        apply(mk(0,0,0,0, 0,1,32'h55550000,0, 0,32'hfffffffc,0,0,0), "wrap2");
        apply(mk(0,0,0,0, 0,0,0,1, 0,32'hfffffffc,1,32'hfffffffc,32'h55550000), "wrap3");
        apply(mk(0,0,0,0, 1,0,0,1, 1,32'h00000000,0,0,0), "wrap4");
        apply(mk(0,0,1,32'h1c000040, 0,1,32'hbad00004,1, 0,32'h00000000,0,0,0), "excw");
        apply(mk(0,0,0,0, 1,0,0,1, 1,32'h1c000040,0,0,0), "excw1");

        // Asynchronous reset while in WAIT takes effect without a clock edge
        #1 resetn = 1'b0;
        #1;
        chk("arst inst_req", {31'd0, inst_req}, 32'd0);
        chk("arst inst_addr", inst_addr, 32'h1c000000);
        chk("arst fd_valid", {31'd0, fd_valid}, 32'd0);
        chk("arst fd_pc", fd_pc, 32'd0);
        chk("arst fd_inst", fd_inst, 32'd0);
        repeat (2) @(posedge clk);
        #1 resetn = 1'b1;
        apply(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000000,0,0,0), "rel0");
        apply(mk(0,0,0,0, 1,0,0,1, 1,32'h1c000000,0,0,0), "rel1");
        apply(mk(0,0,0,0, 0,1,32'h66660000,1, 0,32'h1c000000,0,0,0), "rel2");
        apply(mk(0,0,0,0, 0,0,0,1, 0,32'h1c000000,1,32'h1c000000,32'h66660000), "rel3");
        apply(mk(0,0,0,0, 0,0,0,1, 1,32'h1c000004,0,0,0), "rel4");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
